// File: rtl/iic_gpo_ctrl.sv
// AXI4-Lite master that programs one GPO bit in the IIC core and reads it back.
// The FSM runs write (AW+W), write response, read address and read data phases, each under a timeout.
module iic_gpo_ctrl #(
  parameter logic [8:0] GPO_ADDR = 9'h124,
  parameter int         TIMEOUT  = 255
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        start,
  input  logic        gpo_val,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [8:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [8:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, FIN} state_t;

  localparam logic [9:0] TO_LIM = 10'(TIMEOUT);

  state_t      state, state_nxt;
  logic        aw_done, aw_done_nxt;
  logic        w_done, w_done_nxt;
  logic        gpo_lat, gpo_nxt;
  logic        armed;
  logic [1:0]  err_q, err_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, timeout;
  logic        unused_rdata;

  assign unused_rdata = ^m_axi_rdata[31:1];

  // Valids/readies decode straight from registered state, so they never depend on ready.
  assign m_axi_awvalid = (state == WADDR) && !aw_done;
  assign m_axi_wvalid  = (state == WADDR) && !w_done;
  assign m_axi_bready  = (state == WRESP);
  assign m_axi_arvalid = (state == RADDR);
  assign m_axi_rready  = (state == RDATA);
  assign m_axi_awaddr  = GPO_ADDR;
  assign m_axi_araddr  = GPO_ADDR;
  assign m_axi_wdata   = {31'b0, gpo_lat};
  assign m_axi_wstrb   = 4'b0001;
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign err_code      = err_q;

  assign aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_hs    = m_axi_wvalid  && m_axi_wready;
  assign b_hs    = m_axi_bready  && m_axi_bvalid;
  assign ar_hs   = m_axi_arvalid && m_axi_arready;
  assign r_hs    = m_axi_rready  && m_axi_rvalid;
  assign timeout = (cnt == TO_LIM);

  // Handshakes are tested before timeout so a late handshake still completes the phase.
  always_comb begin
    state_nxt   = state;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    gpo_nxt     = gpo_lat;
    err_nxt     = err_q;
    cnt_nxt     = cnt + 10'd1;
    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        if (start && armed) begin
          state_nxt = WADDR;
          gpo_nxt   = gpo_val;
          err_nxt   = 2'b00;
        end
      end
      WADDR: begin
        aw_done_nxt = aw_done || aw_hs;
        w_done_nxt  = w_done  || w_hs;
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt = WRESP;
          cnt_nxt   = '0;
        end else if (timeout) begin
          state_nxt = FIN;
          err_nxt   = 2'b11;
        end
      end
      WRESP: begin
        if (b_hs) begin
          cnt_nxt = '0;
          if (m_axi_bresp == 2'b00) begin
            state_nxt = RADDR;
          end else begin
            state_nxt = FIN;
            err_nxt   = 2'b01;
          end
        end else if (timeout) begin
          state_nxt = FIN;
          err_nxt   = 2'b11;
        end
      end
      RADDR: begin
        if (ar_hs) begin
          state_nxt = RDATA;
          cnt_nxt   = '0;
        end else if (timeout) begin
          state_nxt = FIN;
          err_nxt   = 2'b11;
        end
      end
      RDATA: begin
        if (r_hs) begin
          state_nxt = FIN;
          if (m_axi_rresp != 2'b00 || m_axi_rdata[0] != gpo_lat) err_nxt = 2'b10;
        end else if (timeout) begin
          state_nxt = FIN;
          err_nxt   = 2'b11;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // armed blocks start on the first edge after reset release.
  always_ff @(posedge s_axi_aclk) begin
    gpo_lat <= gpo_nxt;
    if (!s_axi_aresetn) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 2'b00;
      cnt     <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      err_q   <= err_nxt;
      cnt     <= cnt_nxt;
      armed   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iic_gpo_ctrl.sv
// Bench for iic_gpo_ctrl: configurable AXI4-Lite slave model plus a scoreboard of
// expected err_code and wdata values pushed at start and popped at done / W handshake.
module tb_iic_gpo_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        gpo_val = 1'b0;
  logic        busy, done;
  logic [1:0]  err_code;
  logic [8:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  always #5 clk = ~clk;

  iic_gpo_ctrl #(.GPO_ADDR(9'h124), .TIMEOUT(TO)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn), .start(start), .gpo_val(gpo_val),
    .busy(busy), .done(done), .err_code(err_code),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration and per-transaction observations
  int          aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  bit          rd_force = 1'b0, ar_block = 1'b0;
  logic [31:0] rd_val = 32'h0, wr_cap = 32'h0;
  int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0, ar_hs_n = 0, done_cyc = 0;
  logic [1:0]  err_q[$];
  logic [31:0] wd_q[$];

  // Readies are updated at negedge; a valid&ready pair seen here handshakes at the next posedge.
  always @(negedge clk) begin
    if (awvalid) begin aw_cyc++; awready = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin w_cyc++; wready = (w_cnt >= w_dly); w_cnt++; end
    else begin wready = 1'b0; w_cnt = 0; end
    bvalid  = bready;
    bresp   = b_resp;
    arready = arvalid && !ar_block;
    if (arvalid) ar_cyc++;
    rvalid  = rready;
    rresp   = r_resp;
    rdata   = rd_force ? rd_val : wr_cap;
    if (awvalid && awready) check("awaddr", 32'(awaddr), 32'h124);
    if (wvalid && wready) begin
      wr_cap = wdata;
      if (wd_q.size() > 0) check("wdata", wdata, wd_q.pop_front());
      else check("wdata_unexpected", 32'd1, 32'd0);
      check("wstrb", 32'(wstrb), 32'h1);
    end
    if (arvalid && arready) begin ar_hs_n++; check("araddr", 32'(araddr), 32'h124); end
    if (done) begin
      done_cyc++;
      check("busy_in_fin", 32'(busy), 32'd1);
      if (err_q.size() > 0) check("err_code", 32'(err_code), 32'(err_q.pop_front()));
      else check("done_unexpected", 32'(done), 32'd0);
    end
  end

  task automatic idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_valids"}, {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
  endtask

  task automatic run(input logic gv, input int awd, input int wd, input logic [1:0] br,
                     input logic [1:0] rr, input bit frc, input logic [31:0] rv, input bit arblk,
                     input bit mid_start, input logic [1:0] exp_err,
                     input int exp_aw, input int exp_w, input int exp_ar, input int exp_arhs);
    @(posedge clk); #1;
    aw_dly = awd; w_dly = wd; b_resp = br; r_resp = rr; rd_force = frc; rd_val = rv; ar_block = arblk;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0; ar_hs_n = 0; done_cyc = 0;
    err_q.push_back(exp_err);
    wd_q.push_back({31'b0, gv});
    start = 1'b1; gpo_val = gv;
    @(posedge clk); #1;
    start = 1'b0; gpo_val = ~gv;
    check("busy_after_start", 32'(busy), 32'd1);
    if (mid_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 200; i++) begin
      if (done_cyc != 0) break;
      @(posedge clk); #1;
    end
    if (done_cyc == 0) check("done_seen", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
    idle_outputs("post_txn");
    check("done_pulses", 32'(done_cyc), 32'd1);
    check("err_held", 32'(err_code), 32'(exp_err));
    check("aw_cycles", 32'(aw_cyc), 32'(exp_aw));
    check("w_cycles", 32'(w_cyc), 32'(exp_w));
    check("ar_cycles", 32'(ar_cyc), 32'(exp_ar));
    check("ar_handshakes", 32'(ar_hs_n), 32'(exp_arhs));
  endtask

  initial begin
    // start held high through reset and the first edge after release must be ignored
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle_outputs("in_reset");
    check("err_reset", 32'(err_code), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("start_after_release", 32'(busy), 32'd0);
    start = 1'b0;

    //   gv  awd wd br     rr     frc rv    arblk mid err    aw w  ar    arhs
    run(1'b1, 0, 0, 2'b00, 2'b00, 0, 32'h0, 0,    0,  2'b00, 1, 1, 1,    1);
    run(1'b0, 0, 0, 2'b00, 2'b00, 0, 32'h0, 0,    0,  2'b00, 1, 1, 1,    1);
    run(1'b1, 3, 0, 2'b00, 2'b00, 0, 32'h0, 0,    1,  2'b00, 4, 1, 1,    1);
    run(1'b0, 0, 2, 2'b00, 2'b00, 0, 32'h0, 0,    0,  2'b00, 1, 3, 1,    1);
    run(1'b1, 0, 0, 2'b10, 2'b00, 0, 32'h0, 0,    0,  2'b01, 1, 1, 0,    0);
    run(1'b1, 0, 0, 2'b00, 2'b00, 1, 32'h0, 0,    0,  2'b10, 1, 1, 1,    1);
    run(1'b0, 0, 0, 2'b00, 2'b10, 0, 32'h0, 0,    0,  2'b10, 1, 1, 1,    1);
    // arvalid stays up while the counter climbs 0..TO, then drops on the following edge
    run(1'b1, 0, 0, 2'b00, 2'b00, 0, 32'h0, 1,    0,  2'b11, 1, 1, TO+1, 0);
    run(1'b1, 0, 0, 2'b00, 2'b00, 0, 32'h0, 0,    0,  2'b00, 1, 1, 1,    1);

    // Reset pulse during WRESP abandons the transaction
    @(posedge clk); #1;
    aw_dly = 0; w_dly = 0; b_resp = 2'b00; ar_block = 1'b0; rd_force = 1'b0;
    done_cyc = 0;
    wd_q.push_back(32'h1);
    start = 1'b1; gpo_val = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bready) break;
      @(posedge clk); #1;
    end
    check("reached_wresp", 32'(bready), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    idle_outputs("mid_reset");
    check("err_mid_reset", 32'(err_code), 32'd0);
    rstn = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("start_first_edge", 32'(busy), 32'd0);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_cyc), 32'd0);
    run(1'b1, 0, 0, 2'b00, 2'b00, 0, 32'h0, 0, 0, 2'b00, 1, 1, 1, 1);

    check("scoreboard_empty", 32'(err_q.size() + wd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
